qracc_bank_sequencer: RTL and testbench

QRACC_BANK_SEQUENCER -- requirements
Module: qracc_bank_sequencer

---
 rtl/qracc_pkg.sv | 23 ++
 rtl/qracc_bank_slice_mux.sv | 31 +++
 rtl/qracc_bank_sequencer.sv | 176 +++++++++++++++++
 tb/tb_qracc_bank_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared encodings for the QR-ACC bank sequencer: request opcodes and FSM states.
package qracc_pkg;

  typedef enum logic [1:0] {
    OP_READ        = 2'd0,
    OP_WRITE       = 2'd1,
    OP_COMPUTE     = 2'd2,
    OP_COMPUTE_ALL = 2'd3
  } qracc_op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRECH   = 3'd1,
    ACCESS  = 3'd2,
    COMPUTE = 3'd3,
    RESPOND = 3'd4
  } qracc_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qracc_bank_slice_mux.sv
// Picks one bank's sense-amp and ADC slice out of the flattened per-bank buses.
// Purely combinational; no backpressure.
module qracc_bank_slice_mux
  import qracc_pkg::*;
#(
  parameter int numCols   = 8,
  parameter int compCount = 15,
  parameter int numBanks  = 8,
  parameter int bankW     = 3
) (
  input  logic [bankW-1:0]                     sel,
  input  logic [numBanks*numCols-1:0]          sa_all,
  input  logic [compCount*numCols*numBanks-1:0] adc_all,
  output logic [numCols-1:0]                   sa,
  output logic [compCount*numCols-1:0]         adc
);

  localparam int adcW = compCount * numCols;

  always_comb begin
    sa  = '0;
    adc = '0;
    for (int i = 0; i < numBanks; i++) begin
      if (32'(sel) == i) begin
        sa  = sa_all[i*numCols +: numCols];
        adc = adc_all[i*adcW +: adcW];
      end
    end
  end

endmodule

// File: rtl/qracc_bank_sequencer.sv
// Sequences precharge/access/compute strobes for one bank per request; READ/WRITE respond after pchCycles+2 edges, COMPUTE after pchCycles+cmpCycles+1.
// Accepts only in IDLE; holds the response stable in RESPOND until rsp_ready, with no strobes during the stall.
module qracc_bank_sequencer
  import qracc_pkg::*;
#(
  parameter int numRows    = 128,
  parameter int numCols    = 8,
  parameter int numAdcBits = 4,
  parameter int numBanks   = 8,
  parameter int pchCycles  = 2,
  parameter int cmpCycles  = 3,
  localparam int compCount = 2**numAdcBits - 1,
  localparam int bankW     = $clog2(numBanks)
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [1:0]                            req_op,
  input  logic [bankW-1:0]                      req_bank,
  input  logic [numRows-1:0]                    req_wl,
  input  logic [numCols-1:0]                    req_wdata,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [bankW-1:0]                      rsp_bank,
  output logic                                  rsp_err,
  output logic [numCols-1:0]                    rsp_sa,
  output logic [compCount*numCols-1:0]          rsp_adc,
  output logic [numBanks-1:0]                   bank_select,
  output logic [numRows-1:0]                    WL,
  output logic [numCols-1:0]                    WR_DATA,
  output logic                                  PCH,
  output logic                                  WRITE,
  output logic                                  SAEN,
  output logic                                  M2A,
  output logic                                  M2AB,
  input  logic [numBanks*numCols-1:0]           SA_OUT,
  input  logic [compCount*numCols*numBanks-1:0] ADC_OUT
);

  localparam int cntW = $clog2(max2(pchCycles, cmpCycles) + 1);

  qracc_state_e                 state_q, state_d;
  qracc_op_e                    op_q, op_d;
  logic [bankW-1:0]             bank_q, bank_d;
  logic [numRows-1:0]           wl_q, wl_d;
  logic [numCols-1:0]           wdata_q, wdata_d;
  logic [cntW-1:0]              cnt_q, cnt_d;
  logic                         rsp_err_q, rsp_err_d;
  logic [numCols-1:0]           rsp_sa_q, rsp_sa_d;
  logic [compCount*numCols-1:0] rsp_adc_q, rsp_adc_d;

  logic [numCols-1:0]           sa_sel;
  logic [compCount*numCols-1:0] adc_sel;
  logic                         req_is_all;
  logic                         req_bank_bad;
  logic                         active;

  qracc_bank_slice_mux #(
    .numCols  (numCols),
    .compCount(compCount),
    .numBanks (numBanks),
    .bankW    (bankW)
  ) u_slice_mux (
    .sel    (bank_q),
    .sa_all (SA_OUT),
    .adc_all(ADC_OUT),
    .sa     (sa_sel),
    .adc    (adc_sel)
  );

  assign req_is_all   = (req_op == 2'(OP_COMPUTE_ALL));
  // Only reachable for non-power-of-two bank counts; COMPUTE_ALL ignores req_bank.
  assign req_bank_bad = (32'(req_bank) >= numBanks) && !req_is_all;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    bank_d    = bank_q;
    wl_d      = wl_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    rsp_sa_d  = rsp_sa_q;
    rsp_adc_d = rsp_adc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d      = qracc_op_e'(req_op);
          wl_d      = req_wl;
          wdata_d   = req_wdata;
          bank_d    = req_is_all ? '0 : req_bank;
          cnt_d     = '0;
          rsp_sa_d  = '0;
          rsp_adc_d = '0;
          rsp_err_d = req_bank_bad;
          state_d   = req_bank_bad ? RESPOND : PRECH;
        end
      end
      PRECH: begin
        if (cnt_q == cntW'(pchCycles - 1)) begin
          cnt_d   = '0;
          state_d = (op_q == OP_READ || op_q == OP_WRITE) ? ACCESS : COMPUTE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCESS: begin
        rsp_sa_d = (op_q == OP_READ) ? sa_sel : '0;
        state_d  = RESPOND;
      end
      COMPUTE: begin
        if (cnt_q == cntW'(cmpCycles - 1)) begin
          cnt_d     = '0;
          rsp_adc_d = adc_sel;
          state_d   = RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          if (op_q == OP_COMPUTE_ALL && bank_q != bankW'(numBanks - 1)) begin
            bank_d  = bank_q + 1'b1;
            state_d = PRECH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      bank_q    <= '0;
      wl_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
      rsp_sa_q  <= '0;
      rsp_adc_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      bank_q    <= bank_d;
      wl_q      <= wl_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
      rsp_sa_q  <= rsp_sa_d;
      rsp_adc_q <= rsp_adc_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign active      = (state_q == PRECH) || (state_q == ACCESS) || (state_q == COMPUTE);
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESPOND);
  assign rsp_bank    = bank_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_sa      = rsp_sa_q;
  assign rsp_adc     = rsp_adc_q;
  assign bank_select = active ? (numBanks'(1) << bank_q) : '0;
  assign WL          = active ? wl_q : '0;
  assign WR_DATA     = active ? wdata_q : '0;
  assign PCH         = (state_q == PRECH);
  assign SAEN        = (state_q == ACCESS) && (op_q == OP_READ);
  assign WRITE       = (state_q == ACCESS) && (op_q == OP_WRITE);
  assign M2A         = (state_q == COMPUTE);
  assign M2AB        = !M2A;

endmodule

// File: tb/tb_qracc_bank_sequencer.sv
// Directed bench: table of single-bank requests plus hand sequences for COMPUTE_ALL backpressure, illegal bank and mid-compute reset.
module tb_qracc_bank_sequencer;

  localparam int NR = 16;
  localparam int NC = 8;
  localparam int NB = 4;
  localparam int BW = 2;
  localparam int AW = 15 * NC;

  localparam logic [AW-1:0] ADC0 = {8{15'h007F}};
  localparam logic [AW-1:0] ADC1 = {AW{1'b1}};
  localparam logic [AW-1:0] ADC2 = {8{15'h0003}};
  localparam logic [AW-1:0] ADC3 = {8{15'h1FFF}};

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  // main DUT (4 banks)
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [1:0] req_op = '0;
  logic [BW-1:0] req_bank = '0, rsp_bank;
  logic [NR-1:0] req_wl = '0, WL;
  logic [NC-1:0] req_wdata = '0, rsp_sa, WR_DATA;
  logic [AW-1:0] rsp_adc;
  logic [NB-1:0] bank_select;
  logic PCH, WRITE, SAEN, M2A, M2AB;
  logic [NB*NC-1:0] SA_OUT;
  logic [AW*NB-1:0] ADC_OUT;

  assign SA_OUT  = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
  assign ADC_OUT = {ADC3, ADC2, ADC1, ADC0};

  qracc_bank_sequencer #(
    .numRows(NR), .numCols(NC), .numAdcBits(4), .numBanks(NB),
    .pchCycles(2), .cmpCycles(3)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_bank(req_bank), .req_wl(req_wl), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bank(rsp_bank),
    .rsp_err(rsp_err), .rsp_sa(rsp_sa), .rsp_adc(rsp_adc),
    .bank_select(bank_select), .WL(WL), .WR_DATA(WR_DATA),
    .PCH(PCH), .WRITE(WRITE), .SAEN(SAEN), .M2A(M2A), .M2AB(M2AB),
    .SA_OUT(SA_OUT), .ADC_OUT(ADC_OUT)
  );

  // 6-bank instance, 3-bit bank field, so an out-of-range bank can be driven
  logic e_req_valid = 1'b0, e_req_ready, e_rsp_valid, e_rsp_ready = 1'b0, e_rsp_err;
  logic [1:0] e_req_op = '0;
  logic [2:0] e_req_bank = '0, e_rsp_bank;
  logic [NR-1:0] e_WL;
  logic [NC-1:0] e_rsp_sa, e_WR_DATA;
  logic [AW-1:0] e_rsp_adc;
  logic [5:0] e_bank_select;
  logic e_PCH, e_WRITE, e_SAEN, e_M2A, e_M2AB;
  logic [6*NC-1:0] e_SA_OUT;
  logic [AW*6-1:0] e_ADC_OUT;

  assign e_SA_OUT  = '1;
  assign e_ADC_OUT = '1;

  qracc_bank_sequencer #(
    .numRows(NR), .numCols(NC), .numAdcBits(4), .numBanks(6),
    .pchCycles(2), .cmpCycles(3)
  ) dut_e (
    .CLK(CLK), .nRST(nRST),
    .req_valid(e_req_valid), .req_ready(e_req_ready), .req_op(e_req_op),
    .req_bank(e_req_bank), .req_wl(16'h1234), .req_wdata(8'h77),
    .rsp_valid(e_rsp_valid), .rsp_ready(e_rsp_ready), .rsp_bank(e_rsp_bank),
    .rsp_err(e_rsp_err), .rsp_sa(e_rsp_sa), .rsp_adc(e_rsp_adc),
    .bank_select(e_bank_select), .WL(e_WL), .WR_DATA(e_WR_DATA),
    .PCH(e_PCH), .WRITE(e_WRITE), .SAEN(e_SAEN), .M2A(e_M2A), .M2AB(e_M2AB),
    .SA_OUT(e_SA_OUT), .ADC_OUT(e_ADC_OUT)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [BW-1:0] bank;
    logic [NR-1:0] wl;
    logic [NC-1:0] wdata;
    int            exp_lat;
    int            exp_pch;
    int            exp_saen;
    int            exp_wr;
    int            exp_m2a;
    logic [NC-1:0] exp_sa;
    logic [AW-1:0] exp_adc;
  } vec_t;

  vec_t vecs[6];

  // Latency counts the acceptance edge as edge 1.
  task automatic run_vec(input vec_t v, input int idx);
    int edges, npch, nsaen, nwr, nm2a;
    logic bad;
    edges = 0; npch = 0; nsaen = 0; nwr = 0; nm2a = 0; bad = 1'b0;
    chk($sformatf("v%0d_req_ready", idx), req_ready, 1);
    req_valid = 1'b1; req_op = v.op; req_bank = v.bank;
    req_wl = v.wl; req_wdata = v.wdata;
    step();
    req_valid = 1'b0;
    edges = 1;
    while (!rsp_valid && edges < 40) begin
      if (PCH) npch++;
      if (SAEN) nsaen++;
      if (WRITE) nwr++;
      if (M2A) nm2a++;
      if (int'(PCH) + int'(SAEN) + int'(WRITE) + int'(M2A) != 1) bad = 1'b1;
      if (M2AB !== ~M2A) bad = 1'b1;
      if (bank_select !== (4'b0001 << v.bank)) bad = 1'b1;
      if (WL !== v.wl || WR_DATA !== v.wdata) bad = 1'b1;
      step();
      edges++;
    end
    chk($sformatf("v%0d_latency", idx), edges, v.exp_lat);
    chk($sformatf("v%0d_pch_cycles", idx), npch, v.exp_pch);
    chk($sformatf("v%0d_saen_cycles", idx), nsaen, v.exp_saen);
    chk($sformatf("v%0d_write_cycles", idx), nwr, v.exp_wr);
    chk($sformatf("v%0d_m2a_cycles", idx), nm2a, v.exp_m2a);
    chk($sformatf("v%0d_strobe_invariants", idx), bad, 0);
    chk($sformatf("v%0d_rsp_bank", idx), rsp_bank, v.bank);
    chk($sformatf("v%0d_rsp_err", idx), rsp_err, 0);
    chk($sformatf("v%0d_idle_outputs", idx), {bank_select, WL, WR_DATA, PCH, M2AB}, 1);
    if (v.op == 2'd0 || v.op == 2'd1)
      chk($sformatf("v%0d_rsp_sa", idx), rsp_sa, v.exp_sa);
    else
      chk($sformatf("v%0d_rsp_adc", idx), rsp_adc, v.exp_adc);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_drop", idx), {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    vecs[0] = '{2'd0, 2'd2, 16'h0F0F, 8'h00, 4, 2, 1, 0, 0, 8'hA5, '0};
    vecs[1] = '{2'd1, 2'd3, 16'h8001, 8'h96, 4, 2, 0, 1, 0, 8'h00, '0};
    vecs[2] = '{2'd2, 2'd1, 16'hFFFF, 8'h00, 6, 2, 0, 0, 3, 8'h00, {AW{1'b1}}};
    vecs[3] = '{2'd0, 2'd0, 16'h0001, 8'h00, 4, 2, 1, 0, 0, 8'h3C, '0};
    vecs[4] = '{2'd2, 2'd3, 16'h00F0, 8'h11, 6, 2, 0, 0, 3, 8'h00, {8{15'h1FFF}}};
    vecs[5] = '{2'd0, 2'd1, 16'h4002, 8'h00, 4, 2, 1, 0, 0, 8'h5A, '0};

    // reset state
    #3 nRST = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_bank, rsp_sa}, 0);
    chk("rst_rsp_adc", rsp_adc, 0);
    chk("rst_drive", {bank_select, WL, WR_DATA}, 0);
    chk("rst_strobes", {PCH, SAEN, WRITE, M2A, M2AB}, 5'b00001);
    nRST = 1'b1;
    step();
    chk("post_rst_req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // COMPUTE_ALL with 5 stalled cycles on the bank 0 response
    begin
      int npch, nm2a, nsaen, guard;
      logic bad, stall_bad;
      logic [AW-1:0] adc_exp[4];
      adc_exp[0] = {8{15'h007F}};
      adc_exp[1] = {AW{1'b1}};
      adc_exp[2] = {8{15'h0003}};
      adc_exp[3] = {8{15'h1FFF}};
      npch = 0; nm2a = 0; nsaen = 0; bad = 1'b0; stall_bad = 1'b0;
      req_valid = 1'b1; req_op = 2'd3; req_bank = 2'd2;
      req_wl = 16'hA0A0; req_wdata = 8'h00;
      step();
      req_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
        guard = 0;
        while (!rsp_valid && guard < 40) begin
          if (PCH) npch++;
          if (M2A) nm2a++;
          if (SAEN || WRITE) nsaen++;
          if (bank_select !== (4'b0001 << b)) bad = 1'b1;
          step();
          guard++;
        end
        chk($sformatf("all_b%0d_pass_latency", b), guard, 5);
        chk($sformatf("all_b%0d_rsp_bank", b), rsp_bank, b);
        chk($sformatf("all_b%0d_rsp_adc", b), rsp_adc, adc_exp[b]);
        if (b == 0) begin
          for (int s = 0; s < 5; s++) begin
            step();
            if (!rsp_valid || rsp_bank !== 2'd0 || rsp_adc !== adc_exp[0]) stall_bad = 1'b1;
            if (PCH || SAEN || WRITE || M2A || !M2AB || bank_select !== 4'b0000) stall_bad = 1'b1;
          end
          chk("all_stall_stable", stall_bad, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
      end
      chk("all_done_idle", {rsp_valid, req_ready}, 2'b01);
      chk("all_pch_total", npch, 8);
      chk("all_m2a_total", nm2a, 12);
      chk("all_no_access", nsaen, 0);
      chk("all_bank_select", bad, 0);
    end

    // out-of-range bank on the 6-bank instance
    e_req_valid = 1'b1; e_req_op = 2'd0; e_req_bank = 3'd6;
    step();
    e_req_valid = 1'b0;
    chk("err_rsp_valid", e_rsp_valid, 1);
    chk("err_rsp_err", e_rsp_err, 1);
    chk("err_rsp_sa", e_rsp_sa, 0);
    chk("err_rsp_adc_zero", (e_rsp_adc == '0), 1);
    chk("err_no_strobe", {e_PCH, e_SAEN, e_WRITE, e_M2A, e_bank_select}, 0);
    e_rsp_ready = 1'b1;
    step();
    e_rsp_ready = 1'b0;
    chk("err_back_idle", {e_rsp_valid, e_req_ready}, 2'b01);

    // reset during the second COMPUTE cycle
    req_valid = 1'b1; req_op = 2'd2; req_bank = 2'd1;
    req_wl = 16'h3333; req_wdata = 8'h5C;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_in_compute", {M2A, M2AB, bank_select}, {2'b10, 4'b0010});
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_strobes", {PCH, SAEN, WRITE, M2A, M2AB}, 5'b00001);
    chk("mid_rst_drive", {bank_select, WL, WR_DATA}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_bank, rsp_sa}, 0);
    chk("mid_rst_adc", rsp_adc, 0);
    step();
    #2 nRST = 1'b1;
    #1;
    chk("mid_rel_req_ready", req_ready, 1);
    step();
    run_vec(vecs[0], 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
